clk_period_meter: RTL and testbench

Measures the period of a slow square wave, such as the divided display/step clock, entirely in the fast system clock domain. It synchronises the input, detects rising edges and emits one-cycle `tick` enables. It counts fast-clock cycles between consecutive rising edges and reports each period with a valid strobe. It sits at the consuming end of the clock-divider path, so downstream logic can use clean enables and can check that the divided clock is present and running at the expected rate.

---
 rtl/clk_period_meter.sv | 112 +++++++++++
 tb/tb_clk_period_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: synchronises a slow square wave into the clk domain, emits a tick per
// rising edge and reports the number of clk cycles between consecutive rising edges.
module clk_period_meter #(
  parameter int unsigned        CNT_W      = 24,
  parameter logic [CNT_W-1:0]   MAX_PERIOD = CNT_W'(2_000_000)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_in_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);

  // Valid semantics: period_valid_o is a one-cycle strobe with no back-pressure; period_o
  // changes only in a cycle where period_valid_o is high, or at reset.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic             tick_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  // s1 is the metastability-catching stage; edges are detected one stage further on
  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;
    if (!en_i) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise) begin
            state_d = ST_MEAS;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_MEAS: begin
          // An edge landing exactly on the limit is still a valid period
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == MAX_PERIOD) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = ST_ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= sig_in_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      tick_q    <= rise;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign tick_o         = tick_q;
  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign locked_o       = locked_q;
  assign timeout_o      = timeout_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: drives cycle-level square waves and predicts tick/period/timeout
// events from rising-edge timestamps; a negedge monitor compares them to the outputs.
module tb_clk_period_meter;

  localparam int          CNT_W = 24;
  localparam int          MAXP  = 20;

  logic             clk;
  logic             rst;
  logic             en;
  logic             sig_in;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [1:0]       state;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (24'd20)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .sig_in_i       (sig_in),
    .tick_o         (tick),
    .period_o       (period),
    .period_valid_o (period_valid),
    .locked_o       (locked),
    .timeout_o      (timeout),
    .state_o        (state)
  );

  // ---------------- clock / reset ----------------
  int   cyc = 0;
  logic rst_seen = 1'b1;
  logic en_seen  = 1'b0;

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    en_seen  <= en;
  end

  // ---------------- scoreboard ----------------
  logic [31:0]      exp_tick_q[$];
  logic [31:0]      exp_vcyc_q[$];
  logic [CNT_W-1:0] exp_vper_q[$];
  logic [31:0]      exp_to_q[$];
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // h0..h3 hold the input as sampled at the current edge and the three before it.
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic m_armed = 1'b0;
  logic m_meas  = 1'b0;
  int   m_tprev = 0;

  // Drive the values sampled at the next edge n and predict events appearing right after it.
  task automatic step(input logic s, input logic e, input logic r);
    int   n;
    logic rise;
    @(posedge clk);
    #1;
    sig_in = s;
    en     = e;
    rst    = r;
    n  = cyc + 1;
    h3 = h2; h2 = h1; h1 = h0; h0 = s;
    if (r) begin
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      m_armed = 1'b0;
      m_meas  = 1'b0;
    end else begin
      rise = h2 & ~h3;
      if (rise) exp_tick_q.push_back(n);
      if (!e) begin
        m_armed = 1'b0;
        m_meas  = 1'b0;
      end else if (!m_armed) begin
        m_armed = 1'b1;
      end else if (!m_meas) begin
        if (rise) begin
          m_meas  = 1'b1;
          m_tprev = n;
        end
      end else if (rise) begin
        exp_vcyc_q.push_back(n);
        exp_vper_q.push_back(CNT_W'(n - m_tprev));
        m_tprev = n;
      end else if (n - m_tprev == MAXP) begin
        exp_to_q.push_back(n);
        m_meas = 1'b0;
      end
    end
  endtask

  task automatic run_wave(input int per, input int hi, input int cnt, input logic e);
    for (int c = 0; c < cnt; c++)
      for (int i = 0; i < per; i++)
        step(i < hi, e, 1'b0);
  endtask

  // ---------------- monitor ----------------
  logic             lk_exp  = 1'b0;
  logic [CNT_W-1:0] per_exp = '0;

  always @(negedge clk) begin
    logic             e_t, e_v, e_to;
    logic [CNT_W-1:0] e_p;
    if (cyc >= 1) begin
      e_t = 1'b0; e_v = 1'b0; e_to = 1'b0; e_p = '0;
      if (exp_tick_q.size() > 0 && exp_tick_q[0] == cyc) begin
        e_t = 1'b1;
        void'(exp_tick_q.pop_front());
      end
      if (exp_vcyc_q.size() > 0 && exp_vcyc_q[0] == cyc) begin
        e_v = 1'b1;
        e_p = exp_vper_q.pop_front();
        void'(exp_vcyc_q.pop_front());
      end
      if (exp_to_q.size() > 0 && exp_to_q[0] == cyc) begin
        e_to = 1'b1;
        void'(exp_to_q.pop_front());
      end
      if (rst_seen) begin
        lk_exp  = 1'b0;
        per_exp = '0;
      end else begin
        if (!en_seen) lk_exp = 1'b0;
        if (e_v) begin
          lk_exp  = 1'b1;
          per_exp = e_p;
        end
        if (e_to) lk_exp = 1'b0;
      end
      chk("tick", 32'(tick), 32'(e_t));
      chk("period_valid", 32'(period_valid), 32'(e_v));
      chk("timeout", 32'(timeout), 32'(e_to));
      chk("locked", 32'(locked), 32'(lk_exp));
      chk("period", 32'(period), 32'(per_exp));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int per, hi, cnt, pick, len;
    // reset held with the input toggling, released while the input is high
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // steady period, then a change of period
    run_wave(10, 5, 6, 1'b1);
    run_wave(16, 8, 4, 1'b1);
    // input stops: single timeout, then restart re-arms
    repeat (30) step(1'b0, 1'b1, 1'b0);
    run_wave(10, 5, 3, 1'b1);
    // boundary periods around the limit
    run_wave(20, 10, 4, 1'b1);
    run_wave(21, 11, 4, 1'b1);
    run_wave(12, 6, 3, 1'b1);
    // enable drops on the very edge a rise is seen
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    run_wave(12, 6, 3, 1'b1);
    // reset in the middle of a measurement
    repeat (7) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    run_wave(14, 7, 3, 1'b1);
    // randomized segments
    for (int seg = 0; seg < 80; seg++) begin
      per  = $urandom_range(24, 4);
      hi   = $urandom_range(per - 2, 2);
      cnt  = $urandom_range(4, 1);
      pick = $urandom_range(15, 0);
      len  = $urandom_range(3, 1);
      if (pick == 0) begin
        repeat (len) step(sig_in, en, 1'b1);
      end else if (pick < 3) begin
        repeat (len) step(sig_in, 1'b0, 1'b0);
      end else if (pick == 3) begin
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
      end
      run_wave(per, hi, cnt, 1'b1);
    end
    repeat (30) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("drain_tick", 32'(exp_tick_q.size()), 32'd0);
    chk("drain_valid", 32'(exp_vcyc_q.size()), 32'd0);
    chk("drain_timeout", 32'(exp_to_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
